semaphore_bank_controller: RTL and testbench

- Hardware semaphore bank shared by NumberOfCores CPU cores; each core can acquire, release and read the status of NumberOfSemaphores semaphores.
- Receiving end of the per-core/per-semaphore read-strobe lines produced by the semaphore read controller, plus the acquire/release strobes from the WE decoder.
- Owns lock state, arbitrates contending acquires round-robin, and returns registered grant/ack/status to each core.

---
 rtl/semaphore_bank_controller_if.sv | 37 +++
 rtl/semaphore_bank_controller.sv | 209 ++++++++++++++++++++
 tb/tb_semaphore_bank_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/semaphore_bank_controller_if.sv
// semaphore_bank_controller_if
//   Groups the per-core/per-semaphore strobes and the registered responses of
//   the semaphore bank. Bit c*S+s of each S*C vector belongs to core c,
//   semaphore s.
//   master : CPU/controller side (drives ACQUIRE, RELEASE, READ)
//   slave  : semaphore bank (drives ACK, GRANT, STATUS, READVALID, ERROR)
interface semaphore_bank_controller_if #(
  parameter int NumberOfSemaphores = 8,
  parameter int NumberOfCores      = 2
);
  localparam int N = NumberOfSemaphores * NumberOfCores;

  logic [N-1:0]             SEMAPHOREBANK_ACQUIRE_fromCPU;
  logic [N-1:0]             SEMAPHOREBANK_RELEASE_fromCPU;
  logic [N-1:0]             SEMAPHOREBANK_READ_fromController;
  logic [N-1:0]             SEMAPHOREBANK_ACK_toCPU;
  logic [N-1:0]             SEMAPHOREBANK_GRANT_toCPU;
  logic [NumberOfCores-1:0] SEMAPHOREBANK_STATUS_toCPU;
  logic [NumberOfCores-1:0] SEMAPHOREBANK_READVALID_toCPU;
  logic [NumberOfCores-1:0] SEMAPHOREBANK_ERROR_toCPU;

  modport master (
    output SEMAPHOREBANK_ACQUIRE_fromCPU, SEMAPHOREBANK_RELEASE_fromCPU,
           SEMAPHOREBANK_READ_fromController,
    input  SEMAPHOREBANK_ACK_toCPU, SEMAPHOREBANK_GRANT_toCPU,
           SEMAPHOREBANK_STATUS_toCPU, SEMAPHOREBANK_READVALID_toCPU,
           SEMAPHOREBANK_ERROR_toCPU
  );

  modport slave (
    input  SEMAPHOREBANK_ACQUIRE_fromCPU, SEMAPHOREBANK_RELEASE_fromCPU,
           SEMAPHOREBANK_READ_fromController,
    output SEMAPHOREBANK_ACK_toCPU, SEMAPHOREBANK_GRANT_toCPU,
           SEMAPHOREBANK_STATUS_toCPU, SEMAPHOREBANK_READVALID_toCPU,
           SEMAPHOREBANK_ERROR_toCPU
  );
endinterface

// File: rtl/semaphore_bank_controller.sv
// semaphore_bank_controller
//   Bank of NumberOfSemaphores hardware locks shared by NumberOfCores cores.
//   Each semaphore is FREE or LOCKED(owner); contending acquires are resolved
//   round-robin per semaphore, and a release with waiters hands the lock
//   straight to the next waiter without a FREE cycle. All outputs registered.
//   Ports:
//     SEMAPHOREBANK_CLK      : clock, rising edge
//     SEMAPHOREBANK_RESET_n  : asynchronous active-low reset
//     bus (slave modport)    : acquire/release/read strobes in,
//                              ack/grant/status/readvalid/error out
//   Optional build macro SEMAPHORE_TIMEOUT_EN: adds a per-semaphore hold
//   counter that forces a release (with ERROR to the owner) after
//   TimeoutCycles locked cycles.
module semaphore_bank_controller #(
  parameter int NumberOfSemaphores = 8,
  parameter int NumberOfCores      = 2,
  parameter int TimeoutCycles      = 1024
) (
  input logic                        SEMAPHOREBANK_CLK,
  input logic                        SEMAPHOREBANK_RESET_n,
  semaphore_bank_controller_if.slave bus
);
  localparam int S  = NumberOfSemaphores;
  localparam int C  = NumberOfCores;
  localparam int N  = S * C;
  localparam int OW = $clog2(C);

  typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} sem_state_t;

  sem_state_t    state_q [S];
  sem_state_t    state_n [S];
  logic [OW-1:0] owner_q [S];
  logic [OW-1:0] owner_n [S];
  logic [OW-1:0] rr_q    [S];
  logic [OW-1:0] rr_n    [S];
  logic [C-1:0]  req_v   [S];
  logic [C-1:0]  rel_v   [S];
  logic [N-1:0]  grant_q, grant_n, ack_q, ack_n;
  logic [C-1:0]  status_q, status_n, rv_q, rv_n, err_q, err_n;

`ifdef SEMAPHORE_TIMEOUT_EN
  localparam int CW = $clog2(TimeoutCycles + 1);
  logic [CW-1:0] hold_q [S];
  logic [CW-1:0] hold_n [S];
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles != 0);
`endif

  // First requester at or after start, wrapping at C-1.
  function automatic logic [OW-1:0] rr_pick(input logic [C-1:0] req,
                                            input logic [OW-1:0] start);
    logic [OW-1:0] pick;
    logic          found;
    int            idx;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < C; i++) begin
      idx = (int'(start) + i) % C;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
    return pick;
  endfunction

  function automatic logic [OW-1:0] rr_next(input logic [OW-1:0] p);
    return (int'(p) == C - 1) ? '0 : p + 1'b1;
  endfunction

  // Regroup the core-major strobe vectors per semaphore.
  always_comb begin
    for (int s = 0; s < S; s++) begin
      req_v[s] = '0;
      rel_v[s] = '0;
      for (int c = 0; c < C; c++) begin
        req_v[s][c] = bus.SEMAPHOREBANK_ACQUIRE_fromCPU[c*S+s];
        rel_v[s][c] = bus.SEMAPHOREBANK_RELEASE_fromCPU[c*S+s];
      end
    end
  end

  // Per-semaphore next state, ack and error.
  always_comb begin
    logic          gnt;
    logic          timeout;
    logic [OW-1:0] pick;
    logic [OW-1:0] own;
    logic [C-1:0]  omask;
    ack_n = '0;
    err_n = '0;
    for (int s = 0; s < S; s++) begin
      state_n[s] = state_q[s];
      owner_n[s] = owner_q[s];
      rr_n[s]    = rr_q[s];
      gnt        = 1'b0;
      pick       = rr_q[s];
      own        = owner_q[s];
      omask      = C'(1) << own;
`ifdef SEMAPHORE_TIMEOUT_EN
      timeout    = (state_q[s] == LOCKED) && (hold_q[s] == CW'(TimeoutCycles));
`else
      timeout    = 1'b0;
`endif
      case (state_q[s])
        FREE: begin
          err_n = err_n | rel_v[s];
          if (|req_v[s]) begin
            gnt  = 1'b1;
            pick = rr_pick(req_v[s], rr_q[s]);
          end
        end
        LOCKED: begin
          err_n = err_n | (rel_v[s] & ~omask);
          if (rel_v[s][own] || timeout) begin
            // An owner release on the timeout edge is a clean release.
            if (!rel_v[s][own]) err_n = err_n | omask;
            if (|(req_v[s] & ~omask)) begin
              gnt  = 1'b1;
              pick = rr_pick(req_v[s] & ~omask, rr_q[s]);
            end else if (rel_v[s][own] && req_v[s][own]) begin
              gnt  = 1'b1;
              pick = own;
            end else begin
              state_n[s] = FREE;
            end
          end else if (req_v[s][own]) begin
            ack_n[int'(own)*S+s] = 1'b1;
          end
        end
        default: state_n[s] = FREE;
      endcase
      if (gnt) begin
        state_n[s]            = LOCKED;
        owner_n[s]            = pick;
        rr_n[s]               = rr_next(pick);
        ack_n[int'(pick)*S+s] = 1'b1;
      end
`ifdef SEMAPHORE_TIMEOUT_EN
      if (gnt || state_n[s] == FREE)              hold_n[s] = '0;
      else if (hold_q[s] == CW'(TimeoutCycles))   hold_n[s] = hold_q[s];
      else                                        hold_n[s] = hold_q[s] + 1'b1;
`endif
    end
  end

  always_comb begin
    grant_n = '0;
    for (int s = 0; s < S; s++)
      for (int c = 0; c < C; c++)
        grant_n[c*S+s] = (state_n[s] == LOCKED) && (owner_n[s] == OW'(c));
  end

  // Reads sample pre-update state; lowest semaphore index wins per core.
  always_comb begin
    logic found;
    status_n = status_q;
    rv_n     = '0;
    for (int c = 0; c < C; c++) begin
      found = 1'b0;
      for (int s = 0; s < S; s++) begin
        if (!found && bus.SEMAPHOREBANK_READ_fromController[c*S+s]) begin
          found       = 1'b1;
          rv_n[c]     = 1'b1;
          status_n[c] = (state_q[s] == LOCKED) && (owner_q[s] == OW'(c));
        end
      end
    end
  end

  always_ff @(posedge SEMAPHOREBANK_CLK or negedge SEMAPHOREBANK_RESET_n) begin
    if (!SEMAPHOREBANK_RESET_n) begin
      for (int s = 0; s < S; s++) begin
        state_q[s] <= FREE;
        owner_q[s] <= '0;
        rr_q[s]    <= '0;
`ifdef SEMAPHORE_TIMEOUT_EN
        hold_q[s]  <= '0;
`endif
      end
      grant_q  <= '0;
      ack_q    <= '0;
      status_q <= '0;
      rv_q     <= '0;
      err_q    <= '0;
    end else begin
      for (int s = 0; s < S; s++) begin
        state_q[s] <= state_n[s];
        owner_q[s] <= owner_n[s];
        rr_q[s]    <= rr_n[s];
`ifdef SEMAPHORE_TIMEOUT_EN
        hold_q[s]  <= hold_n[s];
`endif
      end
      grant_q  <= grant_n;
      ack_q    <= ack_n;
      status_q <= status_n;
      rv_q     <= rv_n;
      err_q    <= err_n;
    end
  end

  assign bus.SEMAPHOREBANK_GRANT_toCPU     = grant_q;
  assign bus.SEMAPHOREBANK_ACK_toCPU       = ack_q;
  assign bus.SEMAPHOREBANK_STATUS_toCPU    = status_q;
  assign bus.SEMAPHOREBANK_READVALID_toCPU = rv_q;
  assign bus.SEMAPHOREBANK_ERROR_toCPU     = err_q;
endmodule

// File: tb/tb_semaphore_bank_controller.sv
// tb_semaphore_bank_controller
//   Directed, table-driven bench for semaphore_bank_controller (S=8, C=2).
//   Bit index of the S*C vectors is c*8+s. Inputs change on the falling edge,
//   outputs are sampled 1 time unit after the rising edge.
module tb_semaphore_bank_controller;
  localparam int S = 8;
  localparam int C = 2;
  localparam int N = S * C;
`ifdef SEMAPHORE_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  semaphore_bank_controller_if #(.NumberOfSemaphores(S), .NumberOfCores(C)) bus ();

  semaphore_bank_controller #(
    .NumberOfSemaphores(S),
    .NumberOfCores(C),
    .TimeoutCycles(TO)
  ) dut (
    .SEMAPHOREBANK_CLK(clk),
    .SEMAPHOREBANK_RESET_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] acq;
    logic [N-1:0] rel;
    logic [N-1:0] rd;
    logic [N-1:0] grant;
    logic [N-1:0] ack;
    logic [C-1:0] st;
    logic [C-1:0] rv;
    logic [C-1:0] err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [N-1:0] acq, logic [N-1:0] rel, logic [N-1:0] rd,
                              logic [N-1:0] g, logic [N-1:0] a,
                              logic [C-1:0] st, logic [C-1:0] rv, logic [C-1:0] er);
    vec_t v;
    v.acq = acq; v.rel = rel; v.rd = rd;
    v.grant = g; v.ack = a; v.st = st; v.rv = rv; v.err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] g, input logic [N-1:0] a,
                            input logic [C-1:0] st, input logic [C-1:0] rv,
                            input logic [C-1:0] er);
    chk({tag, ".grant"},  32'(bus.SEMAPHOREBANK_GRANT_toCPU), 32'(g));
    chk({tag, ".ack"},    32'(bus.SEMAPHOREBANK_ACK_toCPU), 32'(a));
    chk({tag, ".status"}, 32'(bus.SEMAPHOREBANK_STATUS_toCPU), 32'(st));
    chk({tag, ".rvalid"}, 32'(bus.SEMAPHOREBANK_READVALID_toCPU), 32'(rv));
    chk({tag, ".error"},  32'(bus.SEMAPHOREBANK_ERROR_toCPU), 32'(er));
  endtask

  task automatic step(input logic [N-1:0] acq, input logic [N-1:0] rel,
                      input logic [N-1:0] rd);
    @(negedge clk);
    bus.SEMAPHOREBANK_ACQUIRE_fromCPU     = acq;
    bus.SEMAPHOREBANK_RELEASE_fromCPU     = rel;
    bus.SEMAPHOREBANK_READ_fromController = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.SEMAPHOREBANK_ACQUIRE_fromCPU     = '0;
    bus.SEMAPHOREBANK_RELEASE_fromCPU     = '0;
    bus.SEMAPHOREBANK_READ_fromController = '0;

    //            acq      rel      rd       grant    ack      st     rv     err
    vecs.push_back(mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0008, 16'h0000, 16'h0000, 16'h0008, 16'h0008, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0000, 16'h0000, 16'h0008, 16'h0008, 16'h0000, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(16'h0000, 16'h0000, 16'h0000, 16'h0008, 16'h0000, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0000, 16'h0000, 16'h0800, 16'h0008, 16'h0000, 2'b01, 2'b10, 2'b00));
    vecs.push_back(mk(16'h0000, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0000, 16'h0000, 16'h0028, 16'h0000, 16'h0000, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk(16'h0000, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b10));
    vecs.push_back(mk(16'h0101, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0100, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0100, 16'h0001, 16'h0000, 16'h0100, 16'h0100, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0000, 2'b10, 2'b10, 2'b00));
    vecs.push_back(mk(16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0101, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0040, 16'h0000, 16'h0000, 16'h0040, 16'h0040, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0040, 16'h0040, 16'h0000, 16'h0040, 16'h0040, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0000, 16'h0000, 16'h0000, 16'h0040, 16'h0000, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0040, 16'h0000, 16'h0000, 16'h0040, 16'h0040, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0004, 16'h0000, 16'h0000, 16'h0004, 16'h0004, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0000, 16'h0400, 16'h0000, 16'h0004, 16'h0000, 2'b10, 2'b00, 2'b10));
    vecs.push_back(mk(16'h0000, 16'h0000, 16'h0000, 16'h0004, 16'h0000, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk(16'h0000, 16'h0080, 16'h0000, 16'h0004, 16'h0000, 2'b10, 2'b00, 2'b01));
    vecs.push_back(mk(16'h1002, 16'h0000, 16'h0000, 16'h1006, 16'h1002, 2'b10, 2'b00, 2'b00));

    // Reset state
    @(posedge clk);
    #1;
    check_outs("reset", '0, '0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].acq, vecs[i].rel, vecs[i].rd);
      check_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].ack,
                 vecs[i].st, vecs[i].rv, vecs[i].err);
    end

    // Core1 waits on s5 for 10 cycles, withdraws, then core0 releases
    step(16'h0020, '0, '0);
    check_outs("s5_acq", 16'h1026, 16'h0020, 2'b10, 2'b00, 2'b00);
    for (int i = 0; i < 10; i++) begin
      step(16'h2000, '0, '0);
      check_outs($sformatf("s5_wait%0d", i), 16'h1026, 16'h0000, 2'b10, 2'b00, 2'b00);
    end
    step('0, 16'h0020, '0);
    check_outs("s5_rel", 16'h1006, 16'h0000, 2'b10, 2'b00, 2'b00);
    step('0, '0, '0);
    check_outs("s5_idle", 16'h1006, 16'h0000, 2'b10, 2'b00, 2'b00);

    // Reset asserted mid-handoff of s2 (core0 releasing, core1 waiting)
    @(negedge clk);
    bus.SEMAPHOREBANK_ACQUIRE_fromCPU = 16'h0400;
    bus.SEMAPHOREBANK_RELEASE_fromCPU = 16'h0004;
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", '0, '0, '0, '0, '0);
    @(negedge clk);
    bus.SEMAPHOREBANK_ACQUIRE_fromCPU = '0;
    bus.SEMAPHOREBANK_RELEASE_fromCPU = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h0202, '0, '0);
    check_outs("post_rst", 16'h0002, 16'h0002, 2'b00, 2'b00, 2'b00);
    step('0, '0, '0);
    check_outs("post_rst_idle", 16'h0002, 16'h0000, 2'b00, 2'b00, 2'b00);

`ifdef SEMAPHORE_TIMEOUT_EN
    // Core0 holds s7 past the limit while core1 waits
    step(16'h0080, '0, '0);
    check_outs("to_acq", 16'h0082, 16'h0080, 2'b00, 2'b00, 2'b00);
    n = 0;
    while (n <= 40) begin
      n++;
      step(16'h8000, '0, '0);
      if (bus.SEMAPHOREBANK_ACK_toCPU[15]) break;
    end
    chk("to_cycles", 32'(n), 32'd17);
    check_outs("to_handoff", 16'h8002, 16'h8000, 2'b00, 2'b00, 2'b01);
`else
    n = 0;
    // Without the timeout, a held lock never moves
    step(16'h0080, '0, '0);
    check_outs("hold_acq", 16'h0082, 16'h0080, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 20; i++) begin
      step(16'h8000, '0, '0);
      if (bus.SEMAPHOREBANK_ACK_toCPU[15]) n++;
    end
    chk("hold_no_ack", 32'(n), 32'd0);
    check_outs("hold_end", 16'h0082, 16'h0000, 2'b00, 2'b00, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
